instruc_loader: RTL

Receive-side counterpart of the transmit instruction buffer. Collects 8-bit bytes from the UART receiver (one per `rx_done_tick`) and reassembles them MSB-first into 32-bit instruction words. Queues completed words in a small show-ahead FIFO for the instruction-memory load path. Detects a halt word that ends a program download and discards stale partial words after an inter-byte timeout.

---
 rtl/instruc_loader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/instruc_loader.sv
// Receive-side instruction loader: packs UART bytes MSB-first into words,
// queues them in a show-ahead FIFO, detects the halt word and drops stale
// partial words after an inter-byte timeout.
module instruc_loader #(
  parameter int unsigned      NB_INST    = 32,
  parameter int unsigned      NB_BYTE    = 8,
  parameter int unsigned      FIFO_DEPTH = 8,
  parameter int unsigned      TIMEOUT    = 100000,
  parameter logic [NB_INST-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_done_tick,
  input  logic [NB_BYTE-1:0]            rx_data,
  input  logic                          i_rd,
  output logic [NB_INST-1:0]            o_word,
  output logic                          o_empty,
  output logic                          o_full,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic [1:0]                    o_byte_idx,
  output logic                          o_overflow,
  output logic                          o_timeout,
  output logic                          o_halt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned SW = NB_INST - NB_BYTE;

  typedef enum logic [1:0] {StIdle, StAssemble, StHalted} state_e;

  state_e             state_q, state_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [SW-1:0]      asm_q, asm_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic               timeout_q, timeout_d;
  logic               halt_q, halt_d;
  logic               ovf_q, ovf_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [NB_INST-1:0] mem_q [FIFO_DEPTH];

  logic               empty, full, push, pop;
  logic [NB_INST-1:0] word_new;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign word_new = {asm_q, rx_data};
  assign pop      = i_rd && !empty;

  // Next-state: byte assembly, push/overflow decision, timeout and halt.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    tmr_d      = tmr_q;
    timeout_d  = 1'b0;
    halt_d     = halt_q;
    ovf_d      = ovf_q;
    push       = 1'b0;
    case (state_q)
      StIdle: begin
        if (rx_done_tick) begin
          asm_d      = word_new[SW-1:0];
          byte_idx_d = 2'd1;
          tmr_d      = '0;
          state_d    = StAssemble;
        end
      end
      StAssemble: begin
        if (rx_done_tick) begin
          tmr_d = '0;
          if (byte_idx_q == 2'd3) begin
            byte_idx_d = 2'd0;
            asm_d      = '0;
            state_d    = StIdle;
            // A pop in the same cycle frees the slot even when full.
            if (!full || i_rd) begin
              push = 1'b1;
              if (word_new == HALT_WORD) begin
                halt_d  = 1'b1;
                state_d = StHalted;
              end
            end else begin
              ovf_d = 1'b1;
            end
          end else begin
            asm_d      = word_new[SW-1:0];
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          timeout_d  = 1'b1;
          byte_idx_d = 2'd0;
          asm_d      = '0;
          tmr_d      = '0;
          state_d    = StIdle;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      StHalted: ;
      default: state_d = StIdle;
    endcase
  end

  assign wr_ptr_d = wr_ptr_q + PW'(push);
  assign rd_ptr_d = rd_ptr_q + PW'(pop);

  // Control and pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      byte_idx_q <= 2'd0;
      asm_q      <= '0;
      tmr_q      <= '0;
      timeout_q  <= 1'b0;
      halt_q     <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      tmr_q      <= tmr_d;
      timeout_q  <= timeout_d;
      halt_q     <= halt_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= word_new;
    end
  end

  assign o_word     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign o_empty    = empty;
  assign o_full     = full;
  assign o_count    = wr_ptr_q - rd_ptr_q;
  assign o_byte_idx = byte_idx_q;
  assign o_overflow = ovf_q;
  assign o_timeout  = timeout_q;
  assign o_halt     = halt_q;

endmodule
